// File: rtl/key_hold_reset_manager_if.sv
// key_hold_reset_manager_if: raw keys in, debounced status, press events and system reset out
//   key_n        raw active-low keys from the board
//   key_down     debounced level, 1 = pressed
//   holding      key held past the long-press threshold
//   short_press  one-cycle pulse on release of a short press
//   long_press   one-cycle pulse on release of a long press
//   mode         per-key toggle flipped by each long press
//   sys_reset_n  stretched active-low system reset
interface key_hold_reset_manager_if #(parameter int N_KEYS = 4);
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] key_down;
    logic [N_KEYS-1:0] holding;
    logic [N_KEYS-1:0] short_press;
    logic [N_KEYS-1:0] long_press;
    logic [N_KEYS-1:0] mode;
    logic sys_reset_n;
    modport master (output key_n, input key_down, holding, short_press, long_press, mode, sys_reset_n);
    modport slave (input key_n, output key_down, holding, short_press, long_press, mode, sys_reset_n);
endinterface

// File: rtl/key_hold_reset_manager.sv
// key_hold_reset_manager: debounces push-buttons, classifies short/long presses, stretches a reset
//   clk      main clock
//   reset_n  asynchronous active-low reset
//   kb       key interface (slave): key_n in; key_down, holding, short_press,
//            long_press, mode, sys_reset_n out
module key_hold_reset_manager #(
    parameter int N_KEYS       = 4,
    parameter int TICK_DIV     = 50_000,
    parameter int DEBOUNCE_MS  = 20,
    parameter int HOLD_MS      = 3000,
    parameter int RESET_KEY    = 0,
    parameter int PULSE_CYCLES = 16
) (
    input logic clk,
    input logic reset_n,
    key_hold_reset_manager_if.slave kb
);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam int HW = $clog2(HOLD_MS + 1);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;
    logic [TW-1:0] tick_cnt;
    logic tick;
    logic [1:0] rdy;
    logic [PW-1:0] pulse_cnt;
    logic [N_KEYS-1:0] sync1, sync2, down, armed, short_q, long_q, mode_q;
    logic [N_KEYS-1:0] short_d, long_d, holding_v;
    logic [DW-1:0] db_cnt [N_KEYS];
    logic [HW-1:0] hold_cnt [N_KEYS];
    logic [HW-1:0] hold_d [N_KEYS];
    state_t state [N_KEYS];
    state_t state_d [N_KEYS];

    assign tick = tick_cnt == TW'(TICK_DIV - 1);

    // rdy marks when the synchronisers hold real key samples instead of their
    // reset value; a key may only arm once it is seen truly released
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt  <= '0;
            rdy       <= '0;
            pulse_cnt <= '0;
            sync1     <= '1;
            sync2     <= '1;
            down      <= '0;
            armed     <= '0;
            short_q   <= '0;
            long_q    <= '0;
            mode_q    <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                db_cnt[i]   <= '0;
                hold_cnt[i] <= '0;
                state[i]    <= IDLE;
            end
        end else begin
            tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
            rdy       <= {rdy[0], 1'b1};
            pulse_cnt <= long_q[RESET_KEY] ? PW'(PULSE_CYCLES) : (pulse_cnt != '0 ? pulse_cnt - PW'(1) : '0);
            sync1     <= kb.key_n;
            sync2     <= sync1;
            armed     <= armed | ({N_KEYS{rdy[1]}} & sync2 & ~down);
            short_q   <= short_d;
            long_q    <= long_d;
            mode_q    <= mode_q ^ long_d;
            for (int i = 0; i < N_KEYS; i++) begin
                state[i]    <= state_d[i];
                hold_cnt[i] <= hold_d[i];
                if (!sync2[i] == down[i])
                    db_cnt[i] <= '0;
                else if (tick) begin
                    if (db_cnt[i] == DW'(DEBOUNCE_MS - 1)) begin
                        down[i]   <= !sync2[i];
                        db_cnt[i] <= '0;
                    end else
                        db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // hold_d is used for the release decision so a threshold hit and a
    // release in the same cycle still count as a long press
    always_comb begin
        for (int i = 0; i < N_KEYS; i++) begin
            state_d[i]   = state[i];
            hold_d[i]    = hold_cnt[i];
            short_d[i]   = 1'b0;
            long_d[i]    = 1'b0;
            holding_v[i] = state[i] == LONG;
            case (state[i])
                IDLE: if (down[i] && armed[i]) begin
                    state_d[i] = HELD;
                    hold_d[i]  = '0;
                end
                HELD: begin
                    hold_d[i] = (tick && hold_cnt[i] != HW'(HOLD_MS)) ? hold_cnt[i] + HW'(1) : hold_cnt[i];
                    if (!down[i]) begin
                        state_d[i] = IDLE;
                        long_d[i]  = hold_d[i] == HW'(HOLD_MS);
                        short_d[i] = hold_d[i] != HW'(HOLD_MS);
                    end else if (hold_d[i] == HW'(HOLD_MS))
                        state_d[i] = LONG;
                end
                LONG: if (!down[i]) begin
                    state_d[i] = IDLE;
                    long_d[i]  = 1'b1;
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    assign kb.key_down    = down;
    assign kb.holding     = holding_v;
    assign kb.short_press = short_q;
    assign kb.long_press  = long_q;
    assign kb.mode        = mode_q;
    assign kb.sys_reset_n = reset_n & (pulse_cnt == '0);
endmodule

// File: tb/tb_key_hold_reset_manager.sv
// tb_key_hold_reset_manager: scoreboard bench with a timestamp-based reference model
module tb_key_hold_reset_manager;
    localparam int N = 2, TD = 4, DB = 2, HM = 10;
    int pw [2] = '{5, 120};

    typedef struct { int cyc; int key; int kind; int mode; } ev_t;
    typedef struct { int first; int last; } win_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [N-1:0] keys_n = '1;
    int passed = 0, total = 0;

    ev_t ev_q [$];
    win_t win_q [2][$];
    int cyc = 0;
    logic [N-1:0] h1, h2, p, m_db, m_armed, m_cnt, m_hold, m_mode;
    int ds [N];
    int rise [N];
    logic lng;

    int now;
    ev_t ev;
    win_t w;
    logic sr, obs;
    logic [N-1:0] prev_hold;
    logic in_low [2];
    int lo_start [2];

    key_hold_reset_manager_if #(.N_KEYS(N)) bus ();
    key_hold_reset_manager_if #(.N_KEYS(N)) bus2 ();
    assign bus.key_n  = keys_n;
    assign bus2.key_n = keys_n;

    key_hold_reset_manager #(.N_KEYS(N), .TICK_DIV(TD), .DEBOUNCE_MS(DB), .HOLD_MS(HM),
        .RESET_KEY(0), .PULSE_CYCLES(5)) dut (.clk(clk), .reset_n(reset_n), .kb(bus));
    key_hold_reset_manager #(.N_KEYS(N), .TICK_DIV(TD), .DEBOUNCE_MS(DB), .HOLD_MS(HM),
        .RESET_KEY(0), .PULSE_CYCLES(120)) dut_ext (.clk(clk), .reset_n(reset_n), .kb(bus2));

    always #5 clk = ~clk;

    task automatic chk(string name, int got, int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s got %0d expected %0d at cycle %0d", name, got, exp, cyc);
    endtask

    // number of tick cycles (cycle % TD == TD-1) within [a, b]
    function automatic int nticks(int a, int b);
        return (b + 1) / TD - a / TD;
    endfunction

    function automatic int code(int c, int k, int kind);
        return c * 64 + k * 4 + kind;
    endfunction

    // Reference model: cycle 0 is the first rising edge with reset_n high.
    // Levels, presses and windows are derived from timestamps and tick counts.
    always @(posedge clk) begin
        if (!reset_n) begin
            cyc = 0; h1 = '0; h2 = '0; m_db = '0; m_armed = '0; m_cnt = '0; m_hold = '0; m_mode = '0;
            ev_q.delete(); win_q[0].delete(); win_q[1].delete();
            for (int k = 0; k < N; k++) begin ds[k] = -1; rise[k] = 0; end
        end else begin
            p = h2; h2 = h1; h1 = ~keys_n;
            for (int k = 0; k < N; k++) begin
                if (m_cnt[k] && !m_db[k]) begin
                    lng = nticks(rise[k] + 2, cyc) >= HM;
                    m_mode[k] = m_mode[k] ^ lng;
                    ev_q.push_back('{cyc, k, int'(lng), int'(m_mode[k])});
                    m_cnt[k] = 1'b0; m_hold[k] = 1'b0;
                    if (lng && k == 0)
                        for (int j = 0; j < 2; j++) begin
                            if (win_q[j].size() > 0 && win_q[j][win_q[j].size() - 1].last >= cyc)
                                win_q[j][win_q[j].size() - 1].last = cyc + pw[j];
                            else
                                win_q[j].push_back('{cyc + 1, cyc + pw[j]});
                        end
                end else if (m_cnt[k] && m_db[k] && !m_hold[k] && cyc % TD == TD - 1 && nticks(rise[k] + 2, cyc) == HM) begin
                    ev_q.push_back('{cyc, k, 2, int'(m_mode[k])});
                    m_hold[k] = 1'b1;
                end
                if (cyc >= 2 && !p[k] && !m_db[k]) m_armed[k] = 1'b1;
                if (p[k] == m_db[k]) ds[k] = -1;
                else begin
                    if (ds[k] < 0) ds[k] = cyc;
                    if (cyc % TD == TD - 1 && nticks(ds[k], cyc) == DB) begin
                        m_db[k] = p[k];
                        ds[k] = -1;
                        if (p[k]) begin rise[k] = cyc; m_cnt[k] = m_armed[k]; end
                    end
                end
            end
            cyc++;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT shows an event or a reset window
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_hold = '0;
            in_low[0] = 1'b0; in_low[1] = 1'b0;
        end else begin
            now = cyc - 1;
            chk("key_down", int'(bus.key_down), int'(m_db));
            chk("holding", int'(bus.holding), int'(m_hold));
            while (ev_q.size() > 0 && ev_q[0].cyc < now) begin
                ev = ev_q.pop_front();
                chk("missed_event", -1, code(ev.cyc, ev.key, ev.kind));
            end
            for (int k = 0; k < N; k++)
                for (int kind = 0; kind < 3; kind++) begin
                    obs = kind == 0 ? bus.short_press[k] : kind == 1 ? bus.long_press[k] : (bus.holding[k] & !prev_hold[k]);
                    if (obs) begin
                        if (ev_q.size() == 0) chk("unexpected_event", code(now, k, kind), -1);
                        else begin
                            ev = ev_q.pop_front();
                            chk("event", code(now, k, kind), code(ev.cyc, ev.key, ev.kind));
                            chk("mode", int'(bus.mode[k]), ev.mode);
                        end
                    end
                end
            prev_hold = bus.holding;
            for (int j = 0; j < 2; j++) begin
                sr = (j == 0) ? bus.sys_reset_n : bus2.sys_reset_n;
                if (!sr && !in_low[j]) begin
                    in_low[j] = 1'b1; lo_start[j] = now;
                end else if (sr && in_low[j]) begin
                    in_low[j] = 1'b0;
                    if (win_q[j].size() == 0) chk($sformatf("unexpected_reset_pulse%0d", j), lo_start[j], -1);
                    else begin
                        w = win_q[j].pop_front();
                        chk($sformatf("pulse_start%0d", j), lo_start[j], w.first);
                        chk($sformatf("pulse_end%0d", j), now - 1, w.last);
                    end
                end
            end
        end
    end

    task automatic drive(logic [N-1:0] m, int n);
        keys_n = ~m;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_key_down"}, int'(bus.key_down), 0);
        chk({tag, "_holding"}, int'(bus.holding), 0);
        chk({tag, "_short"}, int'(bus.short_press), 0);
        chk({tag, "_long"}, int'(bus.long_press), 0);
        chk({tag, "_mode"}, int'(bus.mode), 0);
        chk({tag, "_sys_reset_n"}, int'(bus.sys_reset_n), 0);
        chk({tag, "_sys_reset_n_ext"}, int'(bus2.sys_reset_n), 0);
    endtask

    initial begin
        drive('0, 3);
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        #1;
        chk("sys_reset_n_release", int'(bus.sys_reset_n), 1);
        drive('0, 10);
        drive(2'b01, 5);
        drive('0, 40);
        drive(2'b01, 30);
        drive('0, 40);
        chk("mode0_after_short", int'(bus.mode[0]), 0);
        drive(2'b01, 80);
        drive('0, 40);
        chk("mode0_after_long", int'(bus.mode[0]), 1);
        drive(2'b10, 20);
        drive(2'b11, 30);
        drive(2'b10, 30);
        drive('0, 40);
        chk("mode1_after_long", int'(bus.mode[1]), 1);
        chk("mode0_after_indep", int'(bus.mode[0]), 1);
        repeat (25) drive(N'($urandom_range(0, 3)), $urandom_range(1, 90));
        drive('0, 60);
        for (int i = 0; i < 200 && !bus.holding[0]; i++) drive(2'b01, 1);
        chk("holding_before_abort", int'(bus.holding[0]), 1);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        drive(2'b01, 3);
        reset_n = 1'b1;
        #1;
        chk("sys_reset_n_after_abort", int'(bus.sys_reset_n), 1);
        drive(2'b01, 80);
        drive('0, 40);
        drive(2'b01, 30);
        drive('0, 40);
        drive(2'b01, 800);
        drive('0, 12);
        drive(2'b01, 60);
        drive('0, 200);
        chk("events_left", ev_q.size(), 0);
        chk("windows_left", win_q[0].size(), 0);
        chk("windows_left_ext", win_q[1].size(), 0);
        chk("sys_reset_n_idle", int'(bus.sys_reset_n & bus2.sys_reset_n), 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
